// File: rtl/ula_pkg.sv
// Shared frame geometry, clock divider constants and the Spectrum 128K
// contention pattern used by the ULA contention sequencer.
package ula_pkg;

  localparam int FRAME_T    = 70908;
  localparam int LINE_T     = 228;
  localparam int CONT_START = 14361;
  localparam int INT_LEN    = 36;
  localparam int DIV        = 8;

  localparam int DISP_LINES = 192;
  localparam int DISP_COLS  = 128;

  localparam int FT_W  = 17;
  localparam int POS_W = 8;
  localparam int DIV_W = 3;
  localparam int CNT_W = 3;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } cont_state_t;

  // Wait states inserted for a contended access at this 8-T-state phase.
  function automatic logic [2:0] delay_of(input logic [2:0] phase);
    return (phase < 3'd6) ? (3'd6 - phase) : 3'd0;
  endfunction

endpackage

// File: rtl/ula_frame_counter.sv
// T-state divider and frame-position counter: produces the T-state tick,
// the frame T-state, the display position (dh, dv) and the frame interrupt.
module ula_frame_counter
  import ula_pkg::*;
(
  input  logic             clk_sys,
  input  logic             nRESET,
  input  logic             turbo,
  output logic             tick,
  output logic [FT_W-1:0]  frame_t,
  output logic [POS_W-1:0] dh,
  output logic [POS_W-1:0] dv,
  output logic             nINT
);

  logic [DIV_W-1:0] div;
  logic [DIV_W-1:0] div_last;
  logic             turbo_q;

  // turbo is only adopted at a divider wrap so a T-state is never cut short.
  assign div_last = turbo_q ? DIV_W'(DIV / 2 - 1) : DIV_W'(DIV - 1);
  assign tick     = (div == div_last);

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      div     <= '0;
      turbo_q <= turbo;
    end else if (tick) begin
      div     <= '0;
      turbo_q <= turbo;
    end else begin
      div     <= div + 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      frame_t <= '0;
    end else if (tick) begin
      frame_t <= (frame_t == FT_W'(FRAME_T - 1)) ? '0 : frame_t + 1'b1;
    end
  end

  // dv parks at DISP_LINES outside the display until the first contended T-state.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      dh <= '0;
      dv <= POS_W'(DISP_LINES);
    end else if (tick) begin
      if (frame_t == FT_W'(CONT_START - 1)) begin
        dh <= '0;
        dv <= '0;
      end else if (dh == POS_W'(LINE_T - 1)) begin
        dh <= '0;
        if (dv != POS_W'(DISP_LINES)) begin
          dv <= dv + 1'b1;
        end
      end else begin
        dh <= dh + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      nINT <= 1'b1;
    end else begin
      nINT <= (frame_t >= FT_W'(INT_LEN));
    end
  end

endmodule

// File: rtl/ula_contention.sv
// CPU T-state sequencer: grants cpu_ce once per T-state and inserts the 128K
// contention wait states once per machine cycle inside the display fetch window.
module ula_contention
  import ula_pkg::*;
(
  input  logic            clk_sys,
  input  logic            nRESET,
  input  logic            turbo,
  input  logic            cont_en,
  input  logic            cont_req,
  output logic            cpu_ce,
  output logic            stall,
  output logic            nINT,
  output logic [FT_W-1:0] frame_t
);

  logic             tick;
  logic [POS_W-1:0] dh;
  logic [POS_W-1:0] dv;

  ula_frame_counter u_frame (
    .clk_sys (clk_sys),
    .nRESET  (nRESET),
    .turbo   (turbo),
    .tick    (tick),
    .frame_t (frame_t),
    .dh      (dh),
    .dv      (dv),
    .nINT    (nINT)
  );

  logic             window;
  logic [2:0]       delay;
  logic             hit;
  logic             req_done;
  cont_state_t      state;
  cont_state_t      state_n;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] stall_cnt_n;
  logic             ce_n;

  assign window = (dv < POS_W'(DISP_LINES)) && (dh < POS_W'(DISP_COLS));
  assign delay  = delay_of(dh[2:0]);
  assign hit    = cont_req && !req_done && cont_en && !turbo && window && (delay != 3'd0);
  assign stall  = (state == STALL);

  // The first suppressed tick happens in RUN, so STALL only counts delay-1 more.
  always_comb begin
    state_n     = state;
    stall_cnt_n = stall_cnt;
    ce_n        = 1'b0;
    if (tick) begin
      case (state)
        RUN: begin
          if (hit) begin
            state_n     = STALL;
            stall_cnt_n = delay - 3'd1;
          end else begin
            ce_n = 1'b1;
          end
        end
        STALL: begin
          if (stall_cnt != '0) begin
            stall_cnt_n = stall_cnt - 1'b1;
          end else begin
            ce_n    = 1'b1;
            state_n = RUN;
          end
        end
        default: state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state     <= RUN;
      stall_cnt <= '0;
      cpu_ce    <= 1'b0;
    end else begin
      state     <= state_n;
      stall_cnt <= stall_cnt_n;
      cpu_ce    <= ce_n;
    end
  end

  // Any gap in cont_req marks a new machine cycle, re-arming contention.
  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      req_done <= 1'b0;
    end else if (!cont_req) begin
      req_done <= 1'b0;
    end else if (tick && (state == RUN)) begin
      req_done <= 1'b1;
    end
  end

endmodule
